// File: rtl/lcd_hd44780_responder.sv
// Bus-side model of an HD44780 16x2 character LCD. Passively samples the
// controller's EN/RS/RW/DATA bus, decodes each write as an instruction or a
// character, and keeps the DDRAM image, address counter and mode flags.
//
// Optional feature: define LCD_BUSY_CHECK_EN to drop every write that arrives
// while busy is high. Left undefined, writes during BUSY are accepted and
// restart the busy timer, and only writes during the clear sweep are dropped.
//
// Ports:
//   CLOCK_50    in   system clock
//   reset       in   asynchronous, active-low
//   LCD_EN      in   bus enable strobe (asynchronous)
//   LCD_RS      in   0=instruction, 1=data
//   LCD_RW      in   0=write, 1=read
//   LCD_DATA    in   bus data
//   rd_addr     in   DDRAM readback address (HD44780 address map)
//   rd_data     out  DDRAM byte at rd_addr, 1-cycle latency
//   busy        out  busy flag equivalent
//   cursor_addr out  address counter
//   display_on  out  display control bit D
//   entry_inc   out  entry mode I/D
//   two_line    out  function set N
//   cmd_strobe  out  pulse per accepted instruction
//   data_strobe out  pulse per accepted character write
//   err_drop    out  pulse per dropped bus write
`timescale 1ns/1ps
module lcd_hd44780_responder #(
  parameter int unsigned BUSY_CYCLES  = 2000,
  parameter int unsigned CLEAR_CYCLES = 82000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       LCD_EN,
  input  logic       LCD_RS,
  input  logic       LCD_RW,
  input  logic [7:0] LCD_DATA,
  input  logic [6:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic [6:0] cursor_addr,
  output logic       display_on,
  output logic       entry_inc,
  output logic       two_line,
  output logic       cmd_strobe,
  output logic       data_strobe,
  output logic       err_drop
);

  localparam int unsigned DEPTH   = 80;
  localparam int unsigned MAX_CYC = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [7:0]  BLANK   = 8'h20;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_BUSY  = 2'd2;

  // Address counter step with the HD44780 two-line wrap points.
  function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc);
    logic [6:0] r;
    if (inc) begin
      if (a == 7'h27)      r = 7'h40;
      else if (a == 7'h67) r = 7'h00;
      else                 r = a + 7'd1;
    end else begin
      if (a == 7'h00)      r = 7'h67;
      else if (a == 7'h40) r = 7'h27;
      else                 r = a - 7'd1;
    end
    return r;
  endfunction

  function automatic logic [6:0] ddram_index(input logic [6:0] a);
    return (a[6] ? 7'd40 : 7'd0) + {1'b0, a[5:0]};
  endfunction

  function automatic logic col_valid(input logic [6:0] a);
    return a[5:0] <= 6'd39;
  endfunction

  logic       en_meta, en_sync, en_prev;
  logic       rs_meta, rs_sync, rw_meta, rw_sync;
  logic [7:0] data_meta, data_sync;

  logic [1:0]       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [6:0]       sweep, sweep_n, ac_n;
  logic             disp_n, inc_n, two_n, busy_n;
  logic             cmd_n, data_n, drop_n;
  logic             fall_c, write_c, accept_c, we_c;
  logic [6:0]       waddr_c;
  logic [7:0]       wdata_c;
  logic [7:0]       ddram [DEPTH];

  // A transaction is a falling edge of the synchronised enable.
  assign fall_c  = en_prev & ~en_sync;
  assign write_c = fall_c & ~rw_sync;

  // Next-state and datapath decode.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    sweep_n  = sweep;
    ac_n     = cursor_addr;
    disp_n   = display_on;
    inc_n    = entry_inc;
    two_n    = two_line;
    cmd_n    = 1'b0;
    data_n   = 1'b0;
    drop_n   = 1'b0;
    accept_c = 1'b0;
    we_c     = 1'b0;
    waddr_c  = sweep;
    wdata_c  = BLANK;

    case (state)
      ST_CLEAR: begin
        we_c = 1'b1;
        if (sweep == 7'(DEPTH - 1)) begin
          state_n = ST_BUSY;
          cnt_n   = CNT_W'(CLEAR_CYCLES - DEPTH);
        end else begin
          sweep_n = sweep + 7'd1;
        end
        drop_n = write_c;
      end
      ST_BUSY: begin
        if (cnt <= CNT_W'(1)) begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
`ifdef LCD_BUSY_CHECK_EN
        drop_n = write_c;
`else
        accept_c = write_c;
`endif
      end
      default: accept_c = write_c;
    endcase

    if (accept_c) begin
      state_n = ST_BUSY;
      cnt_n   = CNT_W'(BUSY_CYCLES);
      if (rs_sync) begin
        data_n = 1'b1;
        // Off-screen columns are discarded but the counter still moves.
        if (col_valid(cursor_addr)) begin
          we_c    = 1'b1;
          waddr_c = ddram_index(cursor_addr);
          wdata_c = data_sync;
        end
        ac_n = ac_step(cursor_addr, entry_inc);
      end else begin
        cmd_n = 1'b1;
        // Instruction is selected by its highest set bit.
        if (data_sync[7]) begin
          ac_n = data_sync[6:0];
        end else if (data_sync[6]) begin
          // CGRAM address set: accepted, no modelled effect.
        end else if (data_sync[5]) begin
          two_n = data_sync[3];
        end else if (data_sync[4]) begin
          if (!data_sync[3]) ac_n = ac_step(cursor_addr, data_sync[2]);
        end else if (data_sync[3]) begin
          disp_n = data_sync[2];
        end else if (data_sync[2]) begin
          inc_n = data_sync[1];
        end else if (data_sync[1]) begin
          ac_n = 7'h00;
        end else if (data_sync[0]) begin
          state_n = ST_CLEAR;
          sweep_n = 7'd0;
          ac_n    = 7'h00;
          inc_n   = 1'b1;
        end
      end
    end

    busy_n = (state_n != ST_IDLE);
  end

  // State, synchronisers and registered outputs.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      en_meta     <= 1'b0;
      en_sync     <= 1'b0;
      en_prev     <= 1'b0;
      rs_meta     <= 1'b0;
      rs_sync     <= 1'b0;
      rw_meta     <= 1'b0;
      rw_sync     <= 1'b0;
      data_meta   <= 8'h00;
      data_sync   <= 8'h00;
      state       <= ST_CLEAR;
      cnt         <= '0;
      sweep       <= 7'd0;
      cursor_addr <= 7'h00;
      display_on  <= 1'b0;
      entry_inc   <= 1'b1;
      two_line    <= 1'b0;
      busy        <= 1'b1;
      cmd_strobe  <= 1'b0;
      data_strobe <= 1'b0;
      err_drop    <= 1'b0;
      rd_data     <= 8'h00;
    end else begin
      en_meta     <= LCD_EN;
      en_sync     <= en_meta;
      en_prev     <= en_sync;
      rs_meta     <= LCD_RS;
      rs_sync     <= rs_meta;
      rw_meta     <= LCD_RW;
      rw_sync     <= rw_meta;
      data_meta   <= LCD_DATA;
      data_sync   <= data_meta;
      state       <= state_n;
      cnt         <= cnt_n;
      sweep       <= sweep_n;
      cursor_addr <= ac_n;
      display_on  <= disp_n;
      entry_inc   <= inc_n;
      two_line    <= two_n;
      busy        <= busy_n;
      cmd_strobe  <= cmd_n;
      data_strobe <= data_n;
      err_drop    <= drop_n;
      rd_data     <= col_valid(rd_addr) ? ddram[ddram_index(rd_addr)] : BLANK;
    end
  end

  // DDRAM image; contents are rebuilt by the clear sweep after every reset.
  always_ff @(posedge CLOCK_50) begin
    if (we_c) ddram[waddr_c] <= wdata_c;
  end

endmodule

// File: tb/tb_lcd_hd44780_responder.sv
// Directed testbench for lcd_hd44780_responder (BUSY_CYCLES=4, CLEAR_CYCLES=100).
`timescale 1ns/1ps
module tb_lcd_hd44780_responder;

  logic       CLOCK_50 = 1'b0;
  logic       reset;
  logic       LCD_EN, LCD_RS, LCD_RW;
  logic [7:0] LCD_DATA;
  logic [6:0] rd_addr;
  logic [7:0] rd_data;
  logic       busy, display_on, entry_inc, two_line;
  logic       cmd_strobe, data_strobe, err_drop;
  logic [6:0] cursor_addr;

  int errors = 0;
  int checks = 0;
  int cmd_cnt = 0;
  int data_cnt = 0;
  int drop_cnt = 0;

  lcd_hd44780_responder #(.BUSY_CYCLES(4), .CLEAR_CYCLES(100)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .LCD_EN(LCD_EN), .LCD_RS(LCD_RS),
    .LCD_RW(LCD_RW), .LCD_DATA(LCD_DATA), .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .cursor_addr(cursor_addr), .display_on(display_on),
    .entry_inc(entry_inc), .two_line(two_line), .cmd_strobe(cmd_strobe),
    .data_strobe(data_strobe), .err_drop(err_drop)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  always @(negedge CLOCK_50) begin
    if (cmd_strobe)  cmd_cnt++;
    if (data_strobe) data_cnt++;
    if (err_drop)    drop_cnt++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  // One bus write: EN high for 3 clocks, data held one clock past the fall.
  task automatic pulse(input logic rs, input logic rw, input logic [7:0] d);
    LCD_RS = rs; LCD_RW = rw; LCD_DATA = d; LCD_EN = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    LCD_EN = 1'b0;
    @(negedge CLOCK_50);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    repeat (3) @(negedge CLOCK_50);
    while (busy === 1'b1 && n < 500) begin
      @(negedge CLOCK_50);
      n++;
    end
    if (busy !== 1'b0) begin
      checks++; errors++;
      $display("FAIL %s_idle: busy got %b required 0", name, busy);
    end
  endtask

  task automatic wr(input logic rs, input logic [7:0] d);
    pulse(rs, 1'b0, d);
    wait_done("wr");
  endtask

  task automatic read_dd(input logic [6:0] a, output logic [7:0] v);
    rd_addr = a;
    @(negedge CLOCK_50);
    v = rd_data;
  endtask

  task automatic test_reset;
    int n;
    logic [7:0] v;
    reset = 1'b0; LCD_EN = 1'b0; LCD_RS = 1'b0; LCD_RW = 1'b0; LCD_DATA = 8'h00; rd_addr = 7'h00;
    repeat (4) @(negedge CLOCK_50);
    checks++; if (busy !== 1'b1)         begin errors++; $display("FAIL rst_busy: got %b required 1", busy); end
    checks++; if (cursor_addr !== 7'h00) begin errors++; $display("FAIL rst_ac: got %h required 00", cursor_addr); end
    checks++; if (entry_inc !== 1'b1)    begin errors++; $display("FAIL rst_inc: got %b required 1", entry_inc); end
    checks++; if (display_on !== 1'b0)   begin errors++; $display("FAIL rst_disp: got %b required 0", display_on); end
    checks++; if (two_line !== 1'b0)     begin errors++; $display("FAIL rst_two: got %b required 0", two_line); end
    checks++; if (rd_data !== 8'h00)     begin errors++; $display("FAIL rst_rd: got %h required 00", rd_data); end
    checks++; if ({cmd_strobe, data_strobe, err_drop} !== 3'b000)
      begin errors++; $display("FAIL rst_strobes: got %b required 000", {cmd_strobe, data_strobe, err_drop}); end
    reset = 1'b1;
    n = 0;
    while (busy === 1'b1 && n < 1000) begin
      n++;
      @(negedge CLOCK_50);
    end
    checks++; if (n != 100) begin errors++; $display("FAIL rst_busy_len: got %0d required 100", n); end
    for (int i = 0; i < 40; i++) begin
      read_dd(7'(i), v);
      checks++; if (v !== 8'h20) begin errors++; $display("FAIL rst_l0_%0d: got %h required 20", i, v); end
      read_dd(7'(8'h40 + i), v);
      checks++; if (v !== 8'h20) begin errors++; $display("FAIL rst_l1_%0d: got %h required 20", i, v); end
    end
    read_dd(7'h7F, v);
    checks++; if (v !== 8'h20) begin errors++; $display("FAIL rst_offscreen: got %h required 20", v); end
    checks++; if (cursor_addr !== 7'h00) begin errors++; $display("FAIL rst_ac_after: got %h required 00", cursor_addr); end
  endtask

  task automatic test_write_chars;
    logic [7:0] v;
    cmd_cnt = 0; data_cnt = 0; drop_cnt = 0;
    wr(1'b0, 8'h80);
    wr(1'b1, 8'h57);
    wr(1'b1, 8'h65);
    read_dd(7'h00, v);
    checks++; if (v !== 8'h57) begin errors++; $display("FAIL chars_rd0: got %h required 57", v); end
    read_dd(7'h01, v);
    checks++; if (v !== 8'h65) begin errors++; $display("FAIL chars_rd1: got %h required 65", v); end
    checks++; if (cursor_addr !== 7'h02) begin errors++; $display("FAIL chars_ac: got %h required 02", cursor_addr); end
    checks++; if (cmd_cnt != 1)  begin errors++; $display("FAIL chars_cmd_cnt: got %0d required 1", cmd_cnt); end
    checks++; if (data_cnt != 2) begin errors++; $display("FAIL chars_data_cnt: got %0d required 2", data_cnt); end
    checks++; if (drop_cnt != 0) begin errors++; $display("FAIL chars_drop_cnt: got %0d required 0", drop_cnt); end
  endtask

  task automatic test_ac_wrap;
    logic [7:0] v;
    wr(1'b0, 8'hA7);
    wr(1'b1, 8'h41);
    read_dd(7'h27, v);
    checks++; if (v !== 8'h41) begin errors++; $display("FAIL wrap_rd27: got %h required 41", v); end
    checks++; if (cursor_addr !== 7'h40) begin errors++; $display("FAIL wrap_27_40: got %h required 40", cursor_addr); end
    wr(1'b0, 8'h04);
    checks++; if (entry_inc !== 1'b0) begin errors++; $display("FAIL wrap_entry: got %b required 0", entry_inc); end
    wr(1'b0, 8'h80);
    wr(1'b1, 8'h42);
    read_dd(7'h00, v);
    checks++; if (v !== 8'h42) begin errors++; $display("FAIL wrap_rd00: got %h required 42", v); end
    checks++; if (cursor_addr !== 7'h67) begin errors++; $display("FAIL wrap_00_67: got %h required 67", cursor_addr); end
    wr(1'b0, 8'h14);
    checks++; if (cursor_addr !== 7'h00) begin errors++; $display("FAIL shift_67_00: got %h required 00", cursor_addr); end
    wr(1'b0, 8'h10);
    checks++; if (cursor_addr !== 7'h67) begin errors++; $display("FAIL shift_00_67: got %h required 67", cursor_addr); end
    wr(1'b0, 8'hC0);
    wr(1'b0, 8'h10);
    checks++; if (cursor_addr !== 7'h27) begin errors++; $display("FAIL shift_40_27: got %h required 27", cursor_addr); end
  endtask

  task automatic test_display_flags;
    logic [7:0] v;
    int c0, d0;
    wr(1'b0, 8'h0C);
    checks++; if (display_on !== 1'b1) begin errors++; $display("FAIL disp_on: got %b required 1", display_on); end
    wr(1'b0, 8'h08);
    checks++; if (display_on !== 1'b0) begin errors++; $display("FAIL disp_off: got %b required 0", display_on); end
    wr(1'b0, 8'h38);
    checks++; if (two_line !== 1'b1) begin errors++; $display("FAIL two_line: got %b required 1", two_line); end
    c0 = cmd_cnt; d0 = data_cnt;
    pulse(1'b1, 1'b1, 8'h99);
    wait_done("rw");
    checks++; if (cmd_cnt != c0 || data_cnt != d0)
      begin errors++; $display("FAIL rw_strobes: got %0d/%0d required %0d/%0d", cmd_cnt, data_cnt, c0, d0); end
    checks++; if (cursor_addr !== 7'h27) begin errors++; $display("FAIL rw_ac: got %h required 27", cursor_addr); end
    read_dd(7'h27, v);
    checks++; if (v !== 8'h41) begin errors++; $display("FAIL rw_rd27: got %h required 41", v); end
    wr(1'b0, 8'hA8);
    wr(1'b1, 8'h55);
    checks++; if (cursor_addr !== 7'h27) begin errors++; $display("FAIL offscreen_ac: got %h required 27", cursor_addr); end
    read_dd(7'h27, v);
    checks++; if (v !== 8'h41) begin errors++; $display("FAIL offscreen_rd27: got %h required 41", v); end
    read_dd(7'h28, v);
    checks++; if (v !== 8'h20) begin errors++; $display("FAIL offscreen_rd28: got %h required 20", v); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] v;
    cmd_cnt = 0; data_cnt = 0; drop_cnt = 0;
    pulse(1'b0, 1'b0, 8'h80);
    pulse(1'b1, 1'b0, 8'h31);
    wait_done("b2b");
    read_dd(7'h00, v);
    checks++; if (cmd_cnt != 1) begin errors++; $display("FAIL b2b_cmd_cnt: got %0d required 1", cmd_cnt); end
`ifdef LCD_BUSY_CHECK_EN
    checks++; if (v !== 8'h42)   begin errors++; $display("FAIL b2b_rd00: got %h required 42", v); end
    checks++; if (drop_cnt != 1) begin errors++; $display("FAIL b2b_drop: got %0d required 1", drop_cnt); end
    checks++; if (data_cnt != 0) begin errors++; $display("FAIL b2b_data_cnt: got %0d required 0", data_cnt); end
    checks++; if (cursor_addr !== 7'h00) begin errors++; $display("FAIL b2b_ac: got %h required 00", cursor_addr); end
`else
    checks++; if (v !== 8'h31)   begin errors++; $display("FAIL b2b_rd00: got %h required 31", v); end
    checks++; if (drop_cnt != 0) begin errors++; $display("FAIL b2b_drop: got %0d required 0", drop_cnt); end
    checks++; if (data_cnt != 1) begin errors++; $display("FAIL b2b_data_cnt: got %0d required 1", data_cnt); end
    checks++; if (cursor_addr !== 7'h67) begin errors++; $display("FAIL b2b_ac: got %h required 67", cursor_addr); end
`endif
  endtask

  task automatic test_reset_abort;
    int n;
    logic [7:0] v;
    cmd_cnt = 0; data_cnt = 0; drop_cnt = 0;
    pulse(1'b0, 1'b0, 8'h01);
    n = 0;
    while (busy !== 1'b1 && n < 20) begin
      @(negedge CLOCK_50);
      n++;
    end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL clr_busy: got %b required 1", busy); end
    pulse(1'b1, 1'b0, 8'h77);
    repeat (3) @(negedge CLOCK_50);
    checks++; if (drop_cnt != 1) begin errors++; $display("FAIL clr_drop: got %0d required 1", drop_cnt); end
    checks++; if (data_cnt != 0) begin errors++; $display("FAIL clr_data_cnt: got %0d required 0", data_cnt); end
    checks++; if (entry_inc !== 1'b1) begin errors++; $display("FAIL clr_entry: got %b required 1", entry_inc); end
    repeat (33) @(negedge CLOCK_50);
    reset = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    checks++; if (busy !== 1'b1)     begin errors++; $display("FAIL abort_busy: got %b required 1", busy); end
    checks++; if (two_line !== 1'b0) begin errors++; $display("FAIL abort_two: got %b required 0", two_line); end
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL abort_rd: got %h required 00", rd_data); end
    reset = 1'b1;
    n = 0;
    while (busy === 1'b1 && n < 1000) begin
      n++;
      @(negedge CLOCK_50);
    end
    checks++; if (n != 100) begin errors++; $display("FAIL abort_busy_len: got %0d required 100", n); end
    for (int i = 0; i < 40; i++) begin
      read_dd(7'(i), v);
      checks++; if (v !== 8'h20) begin errors++; $display("FAIL abort_l0_%0d: got %h required 20", i, v); end
      read_dd(7'(8'h40 + i), v);
      checks++; if (v !== 8'h20) begin errors++; $display("FAIL abort_l1_%0d: got %h required 20", i, v); end
    end
    checks++; if (entry_inc !== 1'b1)    begin errors++; $display("FAIL abort_entry: got %b required 1", entry_inc); end
    checks++; if (cursor_addr !== 7'h00) begin errors++; $display("FAIL abort_ac: got %h required 00", cursor_addr); end
  endtask

  initial begin
    test_reset;
    test_write_chars;
    test_ac_wrap;
    test_display_flags;
    test_back_to_back;
    test_reset_abort;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
